// File: rtl/knap_pkg.sv
// Shared definitions for the knapsack subset search block.
//   state_t    : search FSM states (IDLE, SCAN, DRAIN)
//   sum_width  : width of a sum of n_items values of item_w bits each
//   idx_width  : width of an item index (at least one bit)
package knap_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Adding n_items values can grow the result by at most clog2(n_items+1) bits,
    // so this width can never overflow.
    function automatic int sum_width(input int item_w, input int n_items);
        return item_w + $clog2(n_items + 1);
    endfunction

    function automatic int idx_width(input int n_items);
        return (n_items > 1) ? $clog2(n_items) : 1;
    endfunction

endpackage

// File: rtl/knap_subset_search_if.sv
// Config/start/result bundle for knap_subset_search.
//   master : drives cfg_*, bounds, start, abort; observes status and results
//   slave  : the search engine
// Handshake: start is a level sampled on a rising edge and is accepted only when
// busy=0; busy rises on the accepting edge and falls on the edge that raises the
// one-cycle done pulse (or on an abort). Results are stable whenever busy=0.
interface knap_subset_search_if #(
    parameter int N_ITEMS = 5,
    parameter int VAL_W   = 8,
    parameter int WGT_W   = 8
);
    localparam int VSUM_W = knap_pkg::sum_width(VAL_W, N_ITEMS);
    localparam int WSUM_W = knap_pkg::sum_width(WGT_W, N_ITEMS);
    localparam int CNT_W  = N_ITEMS + 1;
    localparam int IDX_W  = knap_pkg::idx_width(N_ITEMS);

    logic              cfg_we;
    logic [IDX_W-1:0]  cfg_idx;
    logic [VAL_W-1:0]  cfg_value;
    logic [WGT_W-1:0]  cfg_weight;
    logic [VSUM_W-1:0] min_value;
    logic [WSUM_W-1:0] max_weight;
    logic              start;
    logic              abort;
    logic              busy;
    logic              done;
    logic              found;
    logic [N_ITEMS-1:0] best_subset;
    logic [VSUM_W-1:0] best_value;
    logic [WSUM_W-1:0] best_weight;
    logic [CNT_W-1:0]  valid_count;

    modport master (
        output cfg_we, cfg_idx, cfg_value, cfg_weight,
        output min_value, max_weight, start, abort,
        input  busy, done, found, best_subset, best_value, best_weight, valid_count
    );

    modport slave (
        input  cfg_we, cfg_idx, cfg_value, cfg_weight,
        input  min_value, max_weight, start, abort,
        output busy, done, found, best_subset, best_value, best_weight, valid_count
    );

endinterface

// File: rtl/knap_subset_eval.sv
// Combinational masked sums: total value and total weight of the items whose
// mask bit is set.
//   mask        : bit i selects item i
//   item_value  : packed table of item values
//   item_weight : packed table of item weights
//   sum_value   : total value of selected items (full width)
//   sum_weight  : total weight of selected items (full width)
module knap_subset_eval #(
    parameter int N_ITEMS = 5,
    parameter int VAL_W   = 8,
    parameter int WGT_W   = 8,
    parameter int VSUM_W  = 11,
    parameter int WSUM_W  = 11
) (
    input  logic [N_ITEMS-1:0]            mask,
    input  logic [N_ITEMS-1:0][VAL_W-1:0] item_value,
    input  logic [N_ITEMS-1:0][WGT_W-1:0] item_weight,
    output logic [VSUM_W-1:0]             sum_value,
    output logic [WSUM_W-1:0]             sum_weight
);

    always_comb begin
        sum_value  = '0;
        sum_weight = '0;
        for (int i = 0; i < N_ITEMS; i++) begin
            if (mask[i]) begin
                sum_value  = sum_value  + VSUM_W'(item_value[i]);
                sum_weight = sum_weight + WSUM_W'(item_weight[i]);
            end
        end
    end

endmodule

// File: rtl/knap_subset_search.sv
// Brute-force 0/1 knapsack search. The item table is written over the config
// port while idle; a start then enumerates every subset, one per clock, through
// a two-stage pipeline (sum, then compare) and keeps the best feasible subset
// plus the number of feasible subsets.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : config, bounds, start/abort, status and results (slave side)
//   dbg_state  : current FSM state
module knap_subset_search
    import knap_pkg::*;
#(
    parameter int N_ITEMS = 5,
    parameter int VAL_W   = 8,
    parameter int WGT_W   = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    knap_subset_search_if.slave  bus,
    output state_t               dbg_state
);

    localparam int VSUM_W = sum_width(VAL_W, N_ITEMS);
    localparam int WSUM_W = sum_width(WGT_W, N_ITEMS);
    localparam int CNT_W  = N_ITEMS + 1;

    state_t state;

    logic [N_ITEMS-1:0][VAL_W-1:0] item_value;
    logic [N_ITEMS-1:0][WGT_W-1:0] item_weight;

    // One extra bit: the top bit set means every subset has been issued.
    logic [N_ITEMS:0]   subset_cnt;

    logic               pipe_valid;
    logic [N_ITEMS-1:0] pipe_idx;
    logic [VSUM_W-1:0]  pipe_value;
    logic [WSUM_W-1:0]  pipe_weight;

    logic [VSUM_W-1:0]  min_value_q;
    logic [WSUM_W-1:0]  max_weight_q;

    logic               busy_q;
    logic               done_q;
    logic               found_q;
    logic [N_ITEMS-1:0] best_subset_q;
    logic [VSUM_W-1:0]  best_value_q;
    logic [WSUM_W-1:0]  best_weight_q;
    logic [CNT_W-1:0]   valid_count_q;

    logic [VSUM_W-1:0]  sum_value;
    logic [WSUM_W-1:0]  sum_weight;
    logic               feasible;
    logic               better;

    knap_subset_eval #(
        .N_ITEMS (N_ITEMS),
        .VAL_W   (VAL_W),
        .WGT_W   (WGT_W),
        .VSUM_W  (VSUM_W),
        .WSUM_W  (WSUM_W)
    ) u_eval (
        .mask        (subset_cnt[N_ITEMS-1:0]),
        .item_value  (item_value),
        .item_weight (item_weight),
        .sum_value   (sum_value),
        .sum_weight  (sum_weight)
    );

    // Subsets arrive in ascending index order, so a strict improvement test
    // automatically keeps the earlier index on a full tie.
    always_comb begin
        feasible = (pipe_weight <= max_weight_q) && (pipe_value >= min_value_q);
        better   = !found_q
                || (pipe_value > best_value_q)
                || ((pipe_value == best_value_q) && (pipe_weight < best_weight_q));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            item_value    <= '0;
            item_weight   <= '0;
            subset_cnt    <= '0;
            pipe_valid    <= 1'b0;
            pipe_idx      <= '0;
            pipe_value    <= '0;
            pipe_weight   <= '0;
            min_value_q   <= '0;
            max_weight_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            found_q       <= 1'b0;
            best_subset_q <= '0;
            best_value_q  <= '0;
            best_weight_q <= '0;
            valid_count_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.cfg_we && (int'(bus.cfg_idx) < N_ITEMS)) begin
                        item_value[bus.cfg_idx]  <= bus.cfg_value;
                        item_weight[bus.cfg_idx] <= bus.cfg_weight;
                    end
                    if (bus.start) begin
                        state         <= ST_SCAN;
                        min_value_q   <= bus.min_value;
                        max_weight_q  <= bus.max_weight;
                        subset_cnt    <= '0;
                        pipe_valid    <= 1'b0;
                        busy_q        <= 1'b1;
                        found_q       <= 1'b0;
                        best_subset_q <= '0;
                        best_value_q  <= '0;
                        best_weight_q <= '0;
                        valid_count_q <= '0;
                    end
                end

                ST_SCAN: begin
                    if (bus.abort) begin
                        state      <= ST_IDLE;
                        busy_q     <= 1'b0;
                        pipe_valid <= 1'b0;
                    end else begin
                        // Stage 1: register the sums of the subset being issued.
                        pipe_valid  <= !subset_cnt[N_ITEMS];
                        pipe_idx    <= subset_cnt[N_ITEMS-1:0];
                        pipe_value  <= sum_value;
                        pipe_weight <= sum_weight;
                        if (!subset_cnt[N_ITEMS]) begin
                            subset_cnt <= subset_cnt + {{N_ITEMS{1'b0}}, 1'b1};
                        end
                        // Stage 2: judge the previously registered subset.
                        if (pipe_valid && feasible) begin
                            valid_count_q <= valid_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                            if (better) begin
                                found_q       <= 1'b1;
                                best_subset_q <= pipe_idx;
                                best_value_q  <= pipe_value;
                                best_weight_q <= pipe_weight;
                            end
                        end
                        if (pipe_valid && (pipe_idx == '1)) begin
                            state <= ST_DRAIN;
                        end
                    end
                end

                ST_DRAIN: begin
                    state      <= ST_IDLE;
                    busy_q     <= 1'b0;
                    pipe_valid <= 1'b0;
                    done_q     <= !bus.abort;
                end

                default: begin
                    state  <= ST_IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy        = busy_q;
    assign bus.done        = done_q;
    assign bus.found       = found_q;
    assign bus.best_subset = best_subset_q;
    assign bus.best_value  = best_value_q;
    assign bus.best_weight = best_weight_q;
    assign bus.valid_count = valid_count_q;
    assign dbg_state       = state;

endmodule

// File: tb/tb_knap_subset_search.sv
// Bench for knap_subset_search: directed table cases, abort and reset-mid-scan,
// then random tables/bounds with writes and starts injected during the scan.
module tb_knap_subset_search;
    import knap_pkg::*;

    localparam int N      = 5;
    localparam int NSUB   = 1 << N;
    localparam int LAT    = NSUB + 2;
    localparam int EXP_W  = 1 + N + 11 + 11 + 6;

    logic   clk;
    logic   rst_n;
    state_t dbg_state;

    knap_subset_search_if #(.N_ITEMS(N), .VAL_W(8), .WGT_W(8)) bus ();

    knap_subset_search #(.N_ITEMS(N), .VAL_W(8), .WGT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;
    logic [EXP_W-1:0] exp_q[$];
    int tv[N];
    int tw[N];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    // Reference: enumerate every subset with plain arithmetic.
    task automatic model_push(input int mn, input int mx);
        int bv, bw, bs, cnt, v, w;
        bit fnd;
        fnd = 0; bv = 0; bw = 0; bs = 0; cnt = 0;
        for (int s = 0; s < NSUB; s++) begin
            v = 0; w = 0;
            for (int i = 0; i < N; i++) begin
                if (((s >> i) & 1) == 1) begin
                    v += tv[i];
                    w += tw[i];
                end
            end
            if (w <= mx && v >= mn) begin
                cnt++;
                if (!fnd || v > bv || (v == bv && w < bw)) begin
                    fnd = 1; bv = v; bw = w; bs = s;
                end
            end
        end
        exp_q.push_back({fnd, bs[N-1:0], bv[10:0], bw[10:0], cnt[5:0]});
    endtask

    // ---------------- driver tasks ----------------
    task automatic write_item(input int idx, input int v, input int w);
        @(negedge clk);
        bus.cfg_we     = 1'b1;
        bus.cfg_idx    = idx[2:0];
        bus.cfg_value  = v[7:0];
        bus.cfg_weight = w[7:0];
        if (idx < N) begin
            tv[idx] = v;
            tw[idx] = w;
        end
        @(negedge clk);
        bus.cfg_we = 1'b0;
    endtask

    task automatic do_start(input int mn, input int mx);
        @(negedge clk);
        bus.min_value  = mn[10:0];
        bus.max_weight = mx[10:0];
        bus.start      = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        chk("busy_after_start", bus.busy, 1);
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_found"}, bus.found, 0);
        chk({tag, "_subset"}, bus.best_subset, 0);
        chk({tag, "_value"}, bus.best_value, 0);
        chk({tag, "_weight"}, bus.best_weight, 0);
        chk({tag, "_count"}, bus.valid_count, 0);
        chk({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    // Run a full search; optionally inject a cfg write and a start mid-scan.
    task automatic run_search(input int mn, input int mx, input bit disturb);
        int done_at;
        logic [EXP_W-1:0] e;
        model_push(mn, mx);
        do_start(mn, mx);
        done_at = -1;
        for (int c = 1; c <= LAT + 20; c++) begin
            @(negedge clk);
            if (disturb && c == 5) begin
                bus.cfg_we     = 1'b1;
                bus.cfg_idx    = 3'($urandom_range(0, 7));
                bus.cfg_value  = 8'($urandom_range(0, 255));
                bus.cfg_weight = 8'($urandom_range(0, 255));
                bus.start      = 1'b1;
            end else begin
                bus.cfg_we = 1'b0;
                bus.start  = 1'b0;
            end
            if (c == LAT - 1) chk("busy_before_done", bus.busy, 1);
            if (bus.done) begin
                done_at = c;
                break;
            end
        end
        chk("done_latency", done_at, LAT);
        chk("busy_at_done", bus.busy, 0);
        e = exp_q.pop_front();
        chk("found", bus.found, e[EXP_W-1]);
        chk("best_subset", bus.best_subset, e[EXP_W-2 -: N]);
        chk("best_value", bus.best_value, e[27:17]);
        chk("best_weight", bus.best_weight, e[16:6]);
        chk("valid_count", bus.valid_count, e[5:0]);
        @(negedge clk);
        chk("done_one_cycle", bus.done, 0);
        chk("hold_value", bus.best_value, e[27:17]);
        chk("hold_count", bus.valid_count, e[5:0]);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int seen;
        rst_n          = 1'b0;
        bus.cfg_we     = 1'b0;
        bus.cfg_idx    = '0;
        bus.cfg_value  = '0;
        bus.cfg_weight = '0;
        bus.min_value  = '0;
        bus.max_weight = '0;
        bus.start      = 1'b0;
        bus.abort      = 1'b0;
        for (int i = 0; i < N; i++) begin
            tv[i] = 0;
            tw[i] = 0;
        end
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        rst_n = 1'b1;

        // Case 1-3: fixed table
        write_item(0, 4, 12);
        write_item(1, 2, 1);
        write_item(2, 2, 2);
        write_item(3, 1, 1);
        write_item(4, 10, 4);
        write_item(6, 200, 200);   // out of range index: ignored
        run_search(15, 16, 1'b0);
        run_search(0, 0, 1'b0);
        run_search(100, 255, 1'b0);

        // Case 5: abort mid-scan, then rerun case 1
        do_start(15, 16);
        repeat (8) @(negedge clk);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk("busy_after_abort", bus.busy, 0);
        chk("state_after_abort", dbg_state, ST_IDLE);
        seen = 0;
        for (int c = 0; c < LAT + 5; c++) begin
            @(negedge clk);
            if (bus.done) seen++;
        end
        chk("no_done_after_abort", seen, 0);
        run_search(15, 16, 1'b0);

        // Case 4: identical items, tie goes to the lowest index
        for (int i = 0; i < N; i++) write_item(i, 3, 5);
        run_search(3, 5, 1'b0);

        // Case 6: write/start during scan, then reset mid-scan
        do_start(15, 16);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            bus.cfg_we     = (c == 5);
            bus.cfg_idx    = '0;
            bus.cfg_value  = 8'd99;
            bus.cfg_weight = 8'd1;
            bus.start      = (c == 5);
            if (c == 19) rst_n = 1'b0;
        end
        bus.cfg_we = 1'b0;
        bus.start  = 1'b0;
        check_zero_outputs("mid_reset");
        rst_n = 1'b1;
        for (int i = 0; i < N; i++) begin
            tv[i] = 0;
            tw[i] = 0;
        end
        run_search(0, 0, 1'b0);

        // Random tables and bounds, with disturbance during the scan
        for (int r = 0; r < 8; r++) begin
            for (int i = 0; i < N; i++) begin
                write_item(i, $urandom_range(0, 30), $urandom_range(0, 30));
            end
            write_item($urandom_range(5, 7), $urandom_range(0, 255), $urandom_range(0, 255));
            run_search($urandom_range(0, 60), $urandom_range(0, 80), 1'b1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
